// File: rtl/alu_word_sequencer.sv
// Multi-cycle wide-word controller for a shared 4-bit registered ALU slice.
// Optional ALU_SEQ_FASTPASS_EN: pure transfers (s=10, cin=0) skip the ALU.
module alu_word_sequencer #(
    parameter int WIDTH   = 16,
    parameter int ALU_LAT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [1:0]       cmd_s,
    input  logic             cmd_cin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_d,
    output logic             rsp_cout,
    output logic             rsp_zero,
    output logic             rsp_ovf,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [1:0]       alu_s,
    output logic             alu_cin,
    input  logic [3:0]       alu_d,
    input  logic             alu_cout
);

    localparam int NIB = WIDTH / 4;
    localparam int NW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int CW  = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t r_state, w_state_nxt;

    logic [WIDTH-1:0] r_a, r_b, r_acc;
    logic [1:0]       r_s;
    logic             r_carry, r_a_msb, r_b_msb;
    logic [NW-1:0]    r_nib;
    logic [CW-1:0]    r_cnt;

    logic             r_cmd_ready, r_rsp_valid, r_rsp_cout, r_rsp_zero, r_rsp_ovf;
    logic [WIDTH-1:0] r_rsp_d;
    logic [3:0]       r_alu_a, r_alu_b;
    logic [1:0]       r_alu_s;
    logic             r_alu_cin;

    logic             w_cmd_ready_nxt, w_rsp_valid_nxt, w_rsp_cout_nxt, w_rsp_zero_nxt, w_rsp_ovf_nxt;
    logic [WIDTH-1:0] w_rsp_d_nxt;
    logic [3:0]       w_alu_a_nxt, w_alu_b_nxt;
    logic [1:0]       w_alu_s_nxt;
    logic             w_alu_cin_nxt;

    logic             w_fast, w_sample, w_last_nib, w_bop_msb;
    logic [WIDTH-1:0] w_final;

`ifdef ALU_SEQ_FASTPASS_EN
    assign w_fast = (cmd_s == 2'b10) && !cmd_cin;
`else
    assign w_fast = 1'b0;
`endif

    assign w_sample   = (r_state == WAIT) && (r_cnt == '0);
    assign w_last_nib = (r_nib == NW'(NIB - 1));
    // Result is built as a right-shifting accumulator: each new nibble enters at the top.
    assign w_final    = WIDTH'({alu_d, r_acc} >> 4);

    always_comb begin
        w_bop_msb = 1'b0;
        case (r_s)
            2'b00:   w_bop_msb = r_b_msb;
            2'b01:   w_bop_msb = ~r_b_msb;
            2'b10:   w_bop_msb = 1'b0;
            default: w_bop_msb = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (cmd_valid) w_state_nxt = w_fast ? DONE : ISSUE;
            ISSUE:   w_state_nxt = WAIT;
            WAIT:    if (r_cnt == '0) w_state_nxt = w_last_nib ? DONE : ISSUE;
            DONE:    if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_cmd_ready_nxt = (w_state_nxt == IDLE);
        w_rsp_valid_nxt = (w_state_nxt == DONE);
        w_rsp_d_nxt     = r_rsp_d;
        w_rsp_cout_nxt  = r_rsp_cout;
        w_rsp_zero_nxt  = r_rsp_zero;
        w_rsp_ovf_nxt   = r_rsp_ovf;
        w_alu_a_nxt     = r_alu_a;
        w_alu_b_nxt     = r_alu_b;
        w_alu_s_nxt     = r_alu_s;
        w_alu_cin_nxt   = r_alu_cin;
        if (r_state == IDLE && cmd_valid && w_fast) begin
            w_rsp_d_nxt    = cmd_a;
            w_rsp_cout_nxt = 1'b0;
            w_rsp_zero_nxt = (cmd_a == '0);
            w_rsp_ovf_nxt  = 1'b0;
        end
        if (r_state == ISSUE) begin
            w_alu_a_nxt   = r_a[3:0];
            w_alu_b_nxt   = r_b[3:0];
            w_alu_s_nxt   = r_s;
            w_alu_cin_nxt = r_carry;
        end
        if (w_sample && w_last_nib) begin
            w_rsp_d_nxt    = w_final;
            w_rsp_cout_nxt = alu_cout;
            w_rsp_zero_nxt = (w_final == '0);
            w_rsp_ovf_nxt  = (r_a_msb == w_bop_msb) && (w_final[WIDTH-1] != r_a_msb);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_s         <= '0;
            r_carry     <= 1'b0;
            r_a_msb     <= 1'b0;
            r_b_msb     <= 1'b0;
            r_nib       <= '0;
            r_cnt       <= '0;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_d     <= '0;
            r_rsp_cout  <= 1'b0;
            r_rsp_zero  <= 1'b0;
            r_rsp_ovf   <= 1'b0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_s     <= '0;
            r_alu_cin   <= 1'b0;
        end else begin
            if (r_state == IDLE && cmd_valid) begin
                r_a     <= cmd_a;
                r_b     <= cmd_b;
                r_s     <= cmd_s;
                r_carry <= cmd_cin;
                r_a_msb <= cmd_a[WIDTH-1];
                r_b_msb <= cmd_b[WIDTH-1];
                r_nib   <= '0;
            end
            // Operands shift down so the next nibble is always at [3:0].
            if (r_state == ISSUE) begin
                r_a   <= r_a >> 4;
                r_b   <= r_b >> 4;
                r_cnt <= CW'(ALU_LAT - 1);
            end
            if (r_state == WAIT) begin
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - CW'(1);
                end else begin
                    r_acc   <= w_final;
                    r_carry <= alu_cout;
                    r_nib   <= r_nib + NW'(1);
                end
            end
            r_cmd_ready <= w_cmd_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_d     <= w_rsp_d_nxt;
            r_rsp_cout  <= w_rsp_cout_nxt;
            r_rsp_zero  <= w_rsp_zero_nxt;
            r_rsp_ovf   <= w_rsp_ovf_nxt;
            r_alu_a     <= w_alu_a_nxt;
            r_alu_b     <= w_alu_b_nxt;
            r_alu_s     <= w_alu_s_nxt;
            r_alu_cin   <= w_alu_cin_nxt;
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_d     = r_rsp_d;
    assign rsp_cout  = r_rsp_cout;
    assign rsp_zero  = r_rsp_zero;
    assign rsp_ovf   = r_rsp_ovf;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_s     = r_alu_s;
    assign alu_cin   = r_alu_cin;

endmodule

// File: tb/tb_alu_word_sequencer.sv
// Bench for alu_word_sequencer: wide-arithmetic reference model, per-cycle compare,
// directed vectors with literal expectations, and a behavioural 4-bit ALU slice.
module tb_alu_word_sequencer;

    localparam int WIDTH   = 16;
    localparam int ALU_LAT = 2;
    localparam int NIB     = WIDTH / 4;
    localparam int SEQ_LAT = NIB * (ALU_LAT + 1) + 1;
`ifdef ALU_SEQ_FASTPASS_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic             clk, reset;
    logic             cmd_valid, cmd_ready, cmd_cin;
    logic [WIDTH-1:0] cmd_a, cmd_b;
    logic [1:0]       cmd_s;
    logic             rsp_valid, rsp_ready, rsp_cout, rsp_zero, rsp_ovf;
    logic [WIDTH-1:0] rsp_d;
    logic [3:0]       alu_a, alu_b, alu_d;
    logic [1:0]       alu_s;
    logic             alu_cin, alu_cout;

    alu_word_sequencer #(.WIDTH(WIDTH), .ALU_LAT(ALU_LAT)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_s(cmd_s), .cmd_cin(cmd_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_d(rsp_d), .rsp_cout(rsp_cout), .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_cin(alu_cin),
        .alu_d(alu_d), .alu_cout(alu_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU slice with a registered output.
    logic [4:0] alu_sum;
    logic [3:0] alu_bop;
    initial begin alu_d = '0; alu_cout = 1'b0; end
    always @(posedge clk) begin
        case (alu_s)
            2'b00:   alu_bop = alu_b;
            2'b01:   alu_bop = ~alu_b;
            2'b10:   alu_bop = 4'h0;
            default: alu_bop = 4'hF;
        endcase
        alu_sum  = {1'b0, alu_a} + {1'b0, alu_bop} + {4'b0, alu_cin};
        alu_d    <= alu_sum[3:0];
        alu_cout <= alu_sum[4];
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] bop_of(input logic [WIDTH-1:0] b, input logic [1:0] s);
        case (s)
            2'b00:   return b;
            2'b01:   return ~b;
            2'b10:   return '0;
            default: return '1;
        endcase
    endfunction

    // Reference model: whole-word arithmetic plus response timing.
    bit               m_live = 1'b0, m_busy = 1'b0, m_fast = 1'b0;
    int               m_cnt = 0, m_lat = SEQ_LAT;
    logic [WIDTH-1:0] m_a, m_b, m_bop, m_d;
    logic [WIDTH:0]   m_sum;
    logic [1:0]       m_s;
    logic             m_cin, m_cout, m_zero, m_ovf;

    function automatic logic carry_into(input int k);
        logic [WIDTH:0] mask, part;
        mask = ((WIDTH+1)'(1) << (4 * k)) - (WIDTH+1)'(1);
        part = ({1'b0, m_a} & mask) + ({1'b0, m_bop} & mask) + (WIDTH+1)'(m_cin);
        return part[4 * k];
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_live = 1'b1;
            m_busy = 1'b0;
        end else if (m_live) begin
            if (!m_busy) begin
                if (cmd_valid) begin
                    m_a   = cmd_a; m_b = cmd_b; m_s = cmd_s; m_cin = cmd_cin;
                    m_bop = bop_of(cmd_b, cmd_s);
                    m_sum = {1'b0, cmd_a} + {1'b0, m_bop} + (WIDTH+1)'(cmd_cin);
                    m_fast = FAST && (cmd_s == 2'b10) && !cmd_cin;
                    m_d    = m_fast ? cmd_a : m_sum[WIDTH-1:0];
                    m_cout = m_fast ? 1'b0 : m_sum[WIDTH];
                    m_zero = (m_d == '0);
                    m_ovf  = !m_fast && (cmd_a[WIDTH-1] == m_bop[WIDTH-1]) && (m_d[WIDTH-1] != cmd_a[WIDTH-1]);
                    m_lat  = m_fast ? 1 : SEQ_LAT;
                    m_cnt  = 1;
                    m_busy = 1'b1;
                end
            end else if (m_cnt >= m_lat && rsp_ready) begin
                m_busy = 1'b0;
            end else begin
                m_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live && !reset) begin
            chk("cmd_ready", cmd_ready, !m_busy);
            chk("rsp_valid", rsp_valid, m_busy && m_cnt >= m_lat);
            if (m_busy && m_cnt >= m_lat) begin
                chk("rsp_d", rsp_d, m_d);
                chk("rsp_cout", rsp_cout, m_cout);
                chk("rsp_zero", rsp_zero, m_zero);
                chk("rsp_ovf", rsp_ovf, m_ovf);
            end
            if (m_busy && !m_fast && m_cnt >= 2) begin
                int k;
                k = (m_cnt - 2) / (ALU_LAT + 1);
                if (k > NIB - 1) k = NIB - 1;
                chk("alu_a", alu_a, 4'(m_a >> (4 * k)));
                chk("alu_b", alu_b, 4'(m_b >> (4 * k)));
                chk("alu_s", alu_s, m_s);
                chk("alu_cin", alu_cin, carry_into(k));
            end
        end
    end

    task automatic run_cmd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [1:0] s, input logic cin,
                           input logic [WIDTH-1:0] exp_d, input logic exp_cout,
                           input logic exp_zero, input logic exp_ovf,
                           input int exp_lat, input int hold);
        int n, lat;
        logic [WIDTH-1:0] held_d;
        cmd_a = a; cmd_b = b; cmd_s = s; cmd_cin = cin;
        cmd_valid = 1'b1;
        rsp_ready = (hold == 0);
        n = 0;
        while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
        chk("accept_wait", n, 0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        chk("latency", lat, exp_lat);
        chk("lit_rsp_d", rsp_d, exp_d);
        chk("lit_rsp_cout", rsp_cout, exp_cout);
        chk("lit_rsp_zero", rsp_zero, exp_zero);
        chk("lit_rsp_ovf", rsp_ovf, exp_ovf);
        chk("model_d", m_d, exp_d);
        chk("model_cout", m_cout, exp_cout);
        chk("model_ovf", m_ovf, exp_ovf);
        held_d = rsp_d;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", rsp_valid, 1'b1);
            chk("hold_d", rsp_d, held_d);
            chk("hold_cmd_ready", cmd_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("back_idle", cmd_ready, 1'b1);
        chk("rsp_dropped", rsp_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        logic [3:0] saved_alu_a;
        reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b1;
        cmd_a = '0; cmd_b = '0; cmd_s = '0; cmd_cin = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_d", rsp_d, '0);
        chk("rst_flags", {rsp_cout, rsp_zero, rsp_ovf}, 3'b000);
        chk("rst_alu", {alu_a, alu_b, alu_s, alu_cin}, '0);

        run_cmd(16'h1234, 16'h0FFF, 2'b00, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0, 13, 0);
        run_cmd(16'h0005, 16'h0007, 2'b01, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 13, 0);
        run_cmd(16'h8000, 16'h0001, 2'b01, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b1, 13, 0);
        run_cmd(16'h1000, 16'h5A5A, 2'b11, 1'b0, 16'h0FFF, 1'b1, 1'b0, 1'b0, 13, 0);
        run_cmd(16'h0000, 16'h0000, 2'b11, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 13, 0);
        run_cmd(16'hFFFF, 16'h1234, 2'b10, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 13, 0);
        run_cmd(16'h7FFF, 16'h0001, 2'b00, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, 13, 5);

        // Reset during the WAIT phase of nibble 2 (cycle 8 after acceptance).
        cmd_a = 16'h1111; cmd_b = 16'h2222; cmd_s = 2'b00; cmd_cin = 1'b0;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_rsp_valid", rsp_valid, 1'b0);
        chk("midrst_cmd_ready", cmd_ready, 1'b1);
        chk("midrst_alu", {alu_a, alu_b, alu_s, alu_cin}, '0);
        run_cmd(16'h0001, 16'h0001, 2'b00, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 13, 0);

        saved_alu_a = alu_a;
        run_cmd(16'hABCD, 16'h0000, 2'b10, 1'b0, 16'hABCD, 1'b0, 1'b0, 1'b0, FAST ? 1 : 13, 0);
        if (FAST) chk("fast_alu_a_unchanged", alu_a, saved_alu_a);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_word_sequencer.md
# alu_word_sequencer

Multi-cycle controller that performs WIDTH-bit ALU operations on the shared registered 4-bit ALU slice (A, B, S, Cin → D, Cout; S: 00 = A+B, 01 = A+~B, 10 = A, 11 = A−1; Cin added in all modes).
- Takes one command at a time over a valid/ready handshake.
- Issues the operands one nibble at a time, LSB first, chaining each nibble's Cout into the next nibble's Cin.
- Assembles the result, flags and final carry, and returns them over a second valid/ready handshake.
- Sits between the instruction/test front end and the single ALU instance, so the ALU datapath is reused for wide words.

## Interface
Parameters:
- WIDTH, 16, operand/result width; multiple of 4, ≥ 4. NIB = WIDTH/4.
- ALU_LAT, 2, cycles from ALU inputs presented to alu_d/alu_cout valid (registered-input, registered-output slice = 2).

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer idle, command accepted when both high
- cmd_a  in  WIDTH  operand A
- cmd_b  in  WIDTH  operand B
- cmd_s  in  2  ALU select
- cmd_cin  in  1  carry into nibble 0
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_d  out  WIDTH  result
- rsp_cout  out  1  carry out of top nibble
- rsp_zero  out  1  rsp_d == 0
- rsp_ovf  out  1  signed overflow
- alu_a, alu_b  out  4  nibble operands to ALU
- alu_s  out  2  select to ALU
- alu_cin  out  1  carry to ALU
- alu_d  in  4  ALU result
- alu_cout  in  1  ALU carry

## Operation
- States: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid: capture a, b, s, cin into internal registers; set nib = 0 and carry = cmd_cin; go to ISSUE.
- ISSUE:
  - Drive alu_a/alu_b with nibble nib of the captured operands.
  - Drive alu_s with the captured s and alu_cin with carry.
  - Load wait counter with ALU_LAT−1; go to WAIT.
- WAIT:
  - Hold all alu_* outputs stable and decrement the counter.
  - At count 0: write alu_d into result nibble nib and set carry = alu_cout.
  - If nib == NIB−1, go to DONE; otherwise increment nib and go to ISSUE.
- DONE:
  - rsp_valid = 1, with rsp_d, rsp_cout (final carry), rsp_zero and rsp_ovf held stable.
  - On rsp_ready: go to IDLE.
  - cmd_ready = 0 in every state except IDLE.
- Carry chaining is uniform for all S values. For S=11, B effectively = all ones, so the wide result equals A + 2^WIDTH − 1 + cin.
- rsp_ovf:
  - Let bop = b (S=00), ~b (S=01), 0 (S=10), all ones (S=11).
  - rsp_ovf = (a[MSB] == bop[MSB]) & (rsp_d[MSB] != a[MSB]).
- alu_d/alu_cout are ignored outside the sample cycle.
- Reset values: state IDLE, cmd_ready 1 in the cycle after reset, rsp_valid 0, rsp_d 0, rsp_cout/zero/ovf 0, alu_a/b/s/cin 0.
- Reset asserted mid-operation: the command is discarded and no response is produced. The ALU's own pipeline contents are ignored after reset.

## Timing
- Each nibble occupies ALU_LAT+1 cycles (1 ISSUE + ALU_LAT WAIT).
- Command accepted at edge E0 → rsp_valid high from cycle E0 + NIB·(ALU_LAT+1) + 1. Defaults: 13 cycles after acceptance.
- Throughput: one command per NIB·(ALU_LAT+1) + 2 cycles with rsp_ready held high; the IDLE cycle is mandatory.
- Backpressure: DONE persists indefinitely with rsp_* stable while rsp_ready = 0.

## Configuration
- ALU_SEQ_FASTPASS_EN defined: a command with s=10, cin=0 (pure transfer) bypasses the ALU.
  - Goes IDLE → DONE directly with rsp_d = a, rsp_cout = 0, rsp_ovf = 0, rsp_zero = (a == 0).
  - rsp_valid is high in the cycle after acceptance.
  - alu_* outputs are not changed.
- Undefined: every command, including transfers, goes through the full nibble sequence.

## Test plan
- S=00, cin=0, a=0x1234, b=0x0FFF → rsp_d=0x2233, cout=0, zero=0, ovf=0; rsp_valid exactly 13 cycles after acceptance.
- S=01, cin=1, a=0x0005, b=0x0007 → rsp_d=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001 → 0x7FFF, cout=1, ovf=1.
- S=11, cin=0:
  - a=0x1000 → 0x0FFF, cout=1.
  - a=0x0000 → 0xFFFF, cout=0.
  - S=10, cin=1, a=0xFFFF → 0x0000, cout=1, zero=1.
- S=00, a=0x7FFF, b=0x0001 → 0x8000, ovf=1. Hold rsp_ready=0 for 5 cycles: rsp_* stable and cmd_ready=0 throughout. Release: IDLE next cycle.
- Reset pulsed during WAIT of nibble 2 → next cycle rsp_valid=0, cmd_ready=1, alu_* = 0. A new command 0x0001+0x0001 returns 0x0002.
- Transfer s=10, cin=0, a=0xABCD:
  - With ALU_SEQ_FASTPASS_EN: rsp_valid one cycle after acceptance with rsp_d=0xABCD, and alu_a never changes.
  - Without it: rsp_valid after 13 cycles with rsp_d=0xABCD.
